// File: rtl/icache_ctrl_pkg.sv
// Shared types and helpers for the icache bank dispatch controller.
package icache_ctrl_pkg;

  // Dispatch FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH_ALL = 2'd1,
    SEL_FLUSH = 2'd2,
    WAIT_REL  = 2'd3
  } dispatch_state_e;

  // Default geometry: 16-byte lines interleaved across 8 banks.
  localparam int unsigned DEF_CACHE_LINE_BYTES = 16;
  localparam int unsigned DEF_NB_CACHE_BANKS   = 8;

  // Field widths, never below one bit so they can size declarations.
  localparam int unsigned OFFSET_BITS =
    ($clog2(DEF_CACHE_LINE_BYTES) > 0) ? $clog2(DEF_CACHE_LINE_BYTES) : 1;
  localparam int unsigned BANK_BITS =
    ($clog2(DEF_NB_CACHE_BANKS) > 0) ? $clog2(DEF_NB_CACHE_BANKS) : 1;

  // Owning bank of an address for line-interleaved banks. The bank count is a
  // power of two, so masking with (nb_banks-1) selects the index field; a
  // single bank yields 0.
  function automatic logic [31:0] bank_idx(input logic [63:0] addr,
                                           input int unsigned off_bits,
                                           input int unsigned nb_banks);
    logic [63:0] shifted;
    shifted = addr >> off_bits;
    return 32'(shifted & 64'(nb_banks - 1));
  endfunction

endpackage

// File: rtl/icache_bank_ack_collector.sv
// Per-bank request/ack collector: raises a request vector on start, drops each
// bank's request once its ack is seen, and flags completion when every bank of
// interest has answered.
module icache_bank_ack_collector
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NB_BANKS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [NB_BANKS-1:0] start_mask_i,
  input  logic [NB_BANKS-1:0] ack_i,
  output logic [NB_BANKS-1:0] req_o,
  output logic                all_done_o
);

  logic [NB_BANKS-1:0] req_q, req_d;
  logic [NB_BANKS-1:0] mask_q, mask_d;
  logic                busy_q, busy_d;
  logic [NB_BANKS-1:0] sampled;
  logic [NB_BANKS-1:0] mask_next;

  // Acks only count while the matching request is still up; repeats are
  // therefore ignored. Banks outside the start mask are pre-marked done.
  always_comb begin
    sampled    = req_q & ack_i;
    mask_next  = mask_q | sampled;
    all_done_o = busy_q && (&mask_next);
    req_d      = req_q;
    mask_d     = mask_q;
    busy_d     = busy_q;
    if (start_i) begin
      req_d  = start_mask_i;
      mask_d = ~start_mask_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      req_d  = req_q & ~sampled;
      mask_d = mask_next;
      if (all_done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  // Request, sticky ack mask and busy flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= '0;
      mask_q <= '0;
      busy_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      mask_q <= mask_d;
      busy_q <= busy_d;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/icache_bank_ctrl_dispatch.sv
// Fans bypass, full-flush and selective-flush requests from the icache control
// unit out to the banks and returns one aggregated handshake upstream.
module icache_bank_ctrl_dispatch
  import icache_ctrl_pkg::*;
#(
  parameter int unsigned NB_CACHE_BANKS   = 8,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned CACHE_LINE_BYTES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      bypass_req_i,
  output logic [NB_CACHE_BANKS-1:0] bypass_ack_o,
  input  logic                      flush_req_i,
  output logic                      flush_ack_o,
  input  logic                      sel_flush_req_i,
  input  logic [ADDR_WIDTH-1:0]     sel_flush_addr_i,
  output logic                      sel_flush_ack_o,
  output logic [NB_CACHE_BANKS-1:0] bank_bypass_req_o,
  input  logic [NB_CACHE_BANKS-1:0] bank_bypass_ack_i,
  output logic [NB_CACHE_BANKS-1:0] bank_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] bank_flush_ack_i,
  output logic [NB_CACHE_BANKS-1:0] bank_sel_flush_req_o,
  output logic [ADDR_WIDTH-1:0]     bank_sel_flush_addr_o,
  input  logic [NB_CACHE_BANKS-1:0] bank_sel_flush_ack_i
);

  localparam int unsigned LINE_SHIFT = $clog2(CACHE_LINE_BYTES);
  localparam logic [NB_CACHE_BANKS-1:0] BANK_ONE = NB_CACHE_BANKS'(1);

  dispatch_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]     sel_addr_q, sel_addr_d;
  logic                      absorbed_q, absorbed_d;
  logic                      flush_ack_q, flush_ack_d;
  logic                      sel_ack_q, sel_ack_d;
  logic [NB_CACHE_BANKS-1:0] bank_bypass_req_q;
  logic [NB_CACHE_BANKS-1:0] bypass_ack_q;

  logic [63:0]               addr_ext;
  logic [31:0]               sel_idx;
  logic [NB_CACHE_BANKS-1:0] sel_onehot;

  logic                      coll_start;
  logic [NB_CACHE_BANKS-1:0] coll_start_mask;
  logic [NB_CACHE_BANKS-1:0] coll_ack;
  logic [NB_CACHE_BANKS-1:0] coll_req;
  logic                      coll_done;

  // Owning bank of the incoming selective-flush address, as a one-hot vector.
  always_comb begin
    addr_ext   = 64'(sel_flush_addr_i);
    sel_idx    = bank_idx(addr_ext, LINE_SHIFT, NB_CACHE_BANKS);
    sel_onehot = BANK_ONE << sel_idx;
  end

  // One collector serves both flavours; only the ack source relevant to the
  // current state is fed in, so stray acks of the other kind are ignored.
  assign coll_ack = (state_q == FLUSH_ALL) ? bank_flush_ack_i : bank_sel_flush_ack_i;

  icache_bank_ack_collector #(
    .NB_BANKS (NB_CACHE_BANKS)
  ) u_ack_collector (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (coll_start),
    .start_mask_i (coll_start_mask),
    .ack_i        (coll_ack),
    .req_o        (coll_req),
    .all_done_o   (coll_done)
  );

  // Dispatch FSM: next state, collector start and completion pulses.
  always_comb begin
    state_d         = state_q;
    coll_start      = 1'b0;
    coll_start_mask = '0;
    sel_addr_d      = sel_addr_q;
    absorbed_d      = absorbed_q;
    flush_ack_d     = 1'b0;
    sel_ack_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          // Full flush wins; a concurrent selective request rides along.
          coll_start      = 1'b1;
          coll_start_mask = '1;
          absorbed_d      = sel_flush_req_i;
          state_d         = FLUSH_ALL;
        end else if (sel_flush_req_i) begin
          coll_start      = 1'b1;
          coll_start_mask = sel_onehot;
          sel_addr_d      = sel_flush_addr_i;
          state_d         = SEL_FLUSH;
        end
      end
      FLUSH_ALL: begin
        // A selective request arriving mid-flush is covered by the full flush.
        absorbed_d = absorbed_q | sel_flush_req_i;
        if (coll_done) begin
          flush_ack_d = 1'b1;
          sel_ack_d   = absorbed_q | sel_flush_req_i;
          absorbed_d  = 1'b0;
          state_d     = WAIT_REL;
        end
      end
      SEL_FLUSH: begin
        if (coll_done) begin
          // Upstream samples flush_ack in its selective state too.
          flush_ack_d = 1'b1;
          sel_ack_d   = 1'b1;
          state_d     = WAIT_REL;
        end
      end
      WAIT_REL: begin
        // Hold off until upstream releases both levels to avoid a retrigger.
        if (!flush_req_i && !sel_flush_req_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, latched address and registered ack pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      sel_addr_q  <= '0;
      absorbed_q  <= 1'b0;
      flush_ack_q <= 1'b0;
      sel_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_addr_q  <= sel_addr_d;
      absorbed_q  <= absorbed_d;
      flush_ack_q <= flush_ack_d;
      sel_ack_q   <= sel_ack_d;
    end
  end

  // Bypass path: one register each way, independent of the flush FSM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_bypass_req_q <= '1;
      bypass_ack_q      <= '1;
    end else begin
      bank_bypass_req_q <= {NB_CACHE_BANKS{bypass_req_i}};
      bypass_ack_q      <= bank_bypass_ack_i;
    end
  end

  assign bank_bypass_req_o     = bank_bypass_req_q;
  assign bypass_ack_o          = bypass_ack_q;
  assign bank_flush_req_o      = (state_q == FLUSH_ALL) ? coll_req : '0;
  assign bank_sel_flush_req_o  = (state_q == SEL_FLUSH) ? coll_req : '0;
  assign bank_sel_flush_addr_o = sel_addr_q;
  assign flush_ack_o           = flush_ack_q;
  assign sel_flush_ack_o       = sel_ack_q;

endmodule

// File: tb/tb_icache_bank_ctrl_dispatch.sv
// Self-checking bench for icache_bank_ctrl_dispatch (8 banks, 16-byte lines).
module tb_icache_bank_ctrl_dispatch;

  localparam int unsigned NB = 8;
  localparam int unsigned AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          bypass_req_i;
  logic [NB-1:0] bypass_ack_o;
  logic          flush_req_i;
  logic          flush_ack_o;
  logic          sel_flush_req_i;
  logic [AW-1:0] sel_flush_addr_i;
  logic          sel_flush_ack_o;
  logic [NB-1:0] bank_bypass_req_o;
  logic [NB-1:0] bank_bypass_ack_i;
  logic [NB-1:0] bank_flush_req_o;
  logic [NB-1:0] bank_flush_ack_i;
  logic [NB-1:0] bank_sel_flush_req_o;
  logic [AW-1:0] bank_sel_flush_addr_o;
  logic [NB-1:0] bank_sel_flush_ack_i;

  icache_bank_ctrl_dispatch #(
    .NB_CACHE_BANKS   (NB),
    .ADDR_WIDTH       (AW),
    .CACHE_LINE_BYTES (16)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .bypass_req_i          (bypass_req_i),
    .bypass_ack_o          (bypass_ack_o),
    .flush_req_i           (flush_req_i),
    .flush_ack_o           (flush_ack_o),
    .sel_flush_req_i       (sel_flush_req_i),
    .sel_flush_addr_i      (sel_flush_addr_i),
    .sel_flush_ack_o       (sel_flush_ack_o),
    .bank_bypass_req_o     (bank_bypass_req_o),
    .bank_bypass_ack_i     (bank_bypass_ack_i),
    .bank_flush_req_o      (bank_flush_req_o),
    .bank_flush_ack_i      (bank_flush_ack_i),
    .bank_sel_flush_req_o  (bank_sel_flush_req_o),
    .bank_sel_flush_addr_o (bank_sel_flush_addr_o),
    .bank_sel_flush_ack_i  (bank_sel_flush_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Expected start of a bank request burst.
  typedef struct {
    logic          is_sel;
    logic [NB-1:0] mask;
    logic [AW-1:0] addr;
  } exp_t;

  // Selective-flush vector: address and owning-bank one-hot.
  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] mask;
  } sel_vec_t;

  exp_t     sb_q[$];
  sel_vec_t vecs[7];
  int       n_cmp  = 0;
  int       n_fail = 0;
  logic     prev_any = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // On each new burst of bank requests, pop the expected record and compare.
  task automatic sb_check();
    logic any;
    exp_t e;
    any = (|bank_flush_req_o) || (|bank_sel_flush_req_o);
    if (any && !prev_any) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got flush_req=0x%0h sel_req=0x%0h expected no request",
                 bank_flush_req_o, bank_sel_flush_req_o);
      end else begin
        e = sb_q.pop_front();
        if (e.is_sel) begin
          chk("sb_sel_req", 64'(bank_sel_flush_req_o), 64'(e.mask));
          chk("sb_sel_addr", 64'(bank_sel_flush_addr_o), 64'(e.addr));
          chk("sb_sel_no_full", 64'(bank_flush_req_o), 64'(0));
        end else begin
          chk("sb_full_req", 64'(bank_flush_req_o), 64'(e.mask));
          chk("sb_full_no_sel", 64'(bank_sel_flush_req_o), 64'(0));
        end
      end
    end
    prev_any = any;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] e_req;
    logic [NB-1:0] rot;

    vecs[0] = '{32'h0000_0130, 8'h08};
    vecs[1] = '{32'h0000_0000, 8'h01};
    vecs[2] = '{32'h0000_0070, 8'h80};
    vecs[3] = '{32'h0000_0080, 8'h01};
    vecs[4] = '{32'hFFFF_FFF0, 8'h80};
    vecs[5] = '{32'h1234_5650, 8'h20};
    vecs[6] = '{32'h0000_0124, 8'h04};

    rst_ni               = 1'b0;
    bypass_req_i         = 1'b1;
    bank_bypass_ack_i    = '1;
    flush_req_i          = 1'b0;
    sel_flush_req_i      = 1'b0;
    sel_flush_addr_i     = '0;
    bank_flush_ack_i     = '0;
    bank_sel_flush_ack_i = '0;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_bank_bypass_req", 64'(bank_bypass_req_o), 64'(8'hFF));
    chk("rst_bypass_ack", 64'(bypass_ack_o), 64'(8'hFF));
    chk("rst_flush_req", 64'(bank_flush_req_o), 64'(0));
    chk("rst_sel_req", 64'(bank_sel_flush_req_o), 64'(0));
    chk("rst_addr", 64'(bank_sel_flush_addr_o), 64'(0));
    rst_ni = 1'b1;
    tick();
    chk("rel_bank_bypass_req", 64'(bank_bypass_req_o), 64'(8'hFF));
    chk("rel_bypass_ack", 64'(bypass_ack_o), 64'(8'hFF));
    chk("rel_flush_ack", 64'(flush_ack_o), 64'(0));
    chk("rel_sel_ack", 64'(sel_flush_ack_o), 64'(0));
    chk("rel_flush_req", 64'(bank_flush_req_o), 64'(0));

    // Bypass off, banks answer three cycles later.
    bypass_req_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bank_bypass_ack_i = (c >= 3) ? 8'h00 : 8'hFF;
      chk("byp_bank_req", 64'(bank_bypass_req_o), 64'(0));
      chk("byp_ack", 64'(bypass_ack_o), (c >= 4) ? 64'(0) : 64'(8'hFF));
    end

    // Zero-wait full flush, all banks ack together.
    flush_req_i = 1'b1;
    sb_q.push_back('{1'b0, 8'hFF, 32'h0});
    tick();
    chk("zw_bank_req", 64'(bank_flush_req_o), 64'(8'hFF));
    chk("zw_ack_c1", 64'(flush_ack_o), 64'(0));
    bank_flush_ack_i = 8'hFF;
    tick();
    chk("zw_ack_c2", 64'(flush_ack_o), 64'(1));
    chk("zw_sel_ack_c2", 64'(sel_flush_ack_o), 64'(0));
    chk("zw_bank_req_c2", 64'(bank_flush_req_o), 64'(0));
    bank_flush_ack_i = 8'h00;
    flush_req_i      = 1'b0;
    tick();
    chk("zw_ack_c3", 64'(flush_ack_o), 64'(0));

    // Staggered acks: bank i answers at cycle 2+i; bypass toggles meanwhile.
    flush_req_i = 1'b1;
    sb_q.push_back('{1'b0, 8'hFF, 32'h0});
    for (int c = 1; c <= 11; c++) begin
      tick();
      bank_flush_ack_i = (c >= 2 && c <= 9) ? 8'(1 << (c - 2)) : 8'h00;
      bypass_req_i     = c[0];
      e_req = (c < 2) ? 8'hFF : 8'(8'hFF << (c - 2));
      chk("stg_bank_req", 64'(bank_flush_req_o), 64'(e_req));
      chk("stg_flush_ack", 64'(flush_ack_o), 64'(c == 10));
      chk("stg_sel_ack", 64'(sel_flush_ack_o), 64'(0));
      if (c >= 2) begin
        chk("stg_bypass", 64'(bank_bypass_req_o), (((c - 1) % 2) == 1) ? 64'(8'hFF) : 64'(0));
      end
      if (c == 10) flush_req_i = 1'b0;
    end

    // Selective flush table: owning bank only, latched address, wrong-bank ack ignored.
    for (int v = 0; v < 7; v++) begin
      sel_flush_req_i  = 1'b1;
      sel_flush_addr_i = vecs[v].addr;
      sb_q.push_back('{1'b1, vecs[v].mask, vecs[v].addr});
      tick();
      chk("sel_req_c1", 64'(bank_sel_flush_req_o), 64'(vecs[v].mask));
      rot = {vecs[v].mask[NB-2:0], vecs[v].mask[NB-1]};
      sel_flush_addr_i     = ~vecs[v].addr;
      bank_sel_flush_ack_i = rot;
      tick();
      chk("sel_req_c2", 64'(bank_sel_flush_req_o), 64'(vecs[v].mask));
      chk("sel_addr_c2", 64'(bank_sel_flush_addr_o), 64'(vecs[v].addr));
      chk("sel_ack_c2", 64'(sel_flush_ack_o), 64'(0));
      bank_sel_flush_ack_i = vecs[v].mask;
      tick();
      chk("sel_ack_c3", 64'(sel_flush_ack_o), 64'(1));
      chk("sel_flush_ack_c3", 64'(flush_ack_o), 64'(1));
      chk("sel_req_c3", 64'(bank_sel_flush_req_o), 64'(0));
      sel_flush_req_i      = 1'b0;
      bank_sel_flush_ack_i = '0;
      tick();
      chk("sel_ack_c4", 64'(sel_flush_ack_o), 64'(0));
      chk("sel_flush_ack_c4", 64'(flush_ack_o), 64'(0));
    end

    // Both requests together, held after completion: one full flush, no retrigger.
    flush_req_i      = 1'b1;
    sel_flush_req_i  = 1'b1;
    sel_flush_addr_i = 32'h0000_0130;
    sb_q.push_back('{1'b0, 8'hFF, 32'h0});
    tick();
    chk("both_full_req", 64'(bank_flush_req_o), 64'(8'hFF));
    chk("both_sel_req", 64'(bank_sel_flush_req_o), 64'(0));
    bank_flush_ack_i = 8'hFF;
    tick();
    chk("both_flush_ack", 64'(flush_ack_o), 64'(1));
    chk("both_sel_ack", 64'(sel_flush_ack_o), 64'(1));
    bank_flush_ack_i = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_flush_ack", 64'(flush_ack_o), 64'(0));
      chk("hold_sel_ack", 64'(sel_flush_ack_o), 64'(0));
      chk("hold_bank_req", 64'(bank_flush_req_o | bank_sel_flush_req_o), 64'(0));
    end
    flush_req_i     = 1'b0;
    sel_flush_req_i = 1'b0;
    tick();
    tick();
    chk("drop_bank_req", 64'(bank_flush_req_o | bank_sel_flush_req_o), 64'(0));

    // Reset while half the banks have acked.
    flush_req_i = 1'b1;
    sb_q.push_back('{1'b0, 8'hFF, 32'h0});
    tick();
    bank_flush_ack_i = 8'h0F;
    tick();
    chk("mid_bank_req", 64'(bank_flush_req_o), 64'(8'hF0));
    bank_flush_ack_i = 8'h00;
    #2;
    rst_ni      = 1'b0;
    flush_req_i = 1'b0;
    #1;
    chk("arst_flush_req", 64'(bank_flush_req_o), 64'(0));
    chk("arst_flush_ack", 64'(flush_ack_o), 64'(0));
    chk("arst_bypass_req", 64'(bank_bypass_req_o), 64'(8'hFF));
    chk("arst_bypass_ack", 64'(bypass_ack_o), 64'(8'hFF));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_no_ack", 64'(flush_ack_o), 64'(0));
    end
    rst_ni = 1'b1;
    tick();
    flush_req_i = 1'b1;
    sb_q.push_back('{1'b0, 8'hFF, 32'h0});
    tick();
    chk("post_bank_req", 64'(bank_flush_req_o), 64'(8'hFF));
    bank_flush_ack_i = 8'h0F;
    tick();
    chk("post_req_c2", 64'(bank_flush_req_o), 64'(8'hF0));
    chk("post_ack_c2", 64'(flush_ack_o), 64'(0));
    bank_flush_ack_i = 8'h00;
    tick();
    chk("post_req_c3", 64'(bank_flush_req_o), 64'(8'hF0));
    chk("post_ack_c3", 64'(flush_ack_o), 64'(0));
    bank_flush_ack_i = 8'hF0;
    tick();
    chk("post_ack_c4", 64'(flush_ack_o), 64'(1));
    bank_flush_ack_i = 8'h00;
    flush_req_i      = 1'b0;
    tick();
    chk("post_ack_c5", 64'(flush_ack_o), 64'(0));

    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
